// File: rtl/ram16k_pkg.sv
// Shared constants, FSM states and read-pipeline slot type
// for the ram16k memory tester.
package ram16k_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 15;
    localparam int DEPTH  = 16384;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] add;
    } rd_slot_t;

    function automatic logic [DATA_W-1:0] pattern(
        input logic [ADDR_W-1:0] add,
        input logic [DATA_W-1:0] seed
    );
        return {2'b00, add} ^ seed;
    endfunction

endpackage

// File: rtl/ram16k_rd_pipe.sv
// Read-latency matching delay line carrying the expected data
// and address of each issued read to its compare point.
module ram16k_rd_pipe
    import ram16k_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  rd_slot_t in_slot,
    output rd_slot_t out_slot
);

    rd_slot_t stage [LAT];

    // Shift one slot per cycle; reset flushes every slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= in_slot;
            for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign out_slot = stage[LAT-1];

endmodule

// File: rtl/ram16k_tester.sv
// Write-then-read-back tester for one ram16k instance:
// strided address walk, address-derived pattern, latency-matched compare.
module ram16k_tester
    import ram16k_pkg::*;
#(
    parameter int          RD_LAT = 1,
    parameter logic [15:0] SEED   = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_add,
    output logic              ram_en,
    output logic              ram_r,
    output logic              ram_w,
    output logic [ADDR_W-1:0] ram_add,
    output logic [DATA_W-1:0] ram_d_in,
    input  logic [DATA_W-1:0] ram_d_out
);

    state_t            state;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] stride_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  idx;
    logic [1:0]        dcnt;
    logic [ADDR_W-1:0] next_add;
    rd_slot_t          push;
    rd_slot_t          pop;
    logic              mismatch;

    assign next_add = ram_add + stride_r;

    // A read is in flight to the RAM whenever the registered bus shows one
    assign push.valid = ram_en & ~ram_w;
    assign push.data  = pattern(ram_add, SEED);
    assign push.add   = ram_add;

    assign mismatch = pop.valid && (ram_d_out != pop.data);

    ram16k_rd_pipe #(
        .LAT (RD_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_slot  (push),
        .out_slot (pop)
    );

    // Sequencer: drives the RAM bus and accumulates compare results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            base_r        <= '0;
            stride_r      <= '0;
            cnt_r         <= '0;
            idx           <= '0;
            dcnt          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_add <= '0;
            ram_en        <= 1'b0;
            ram_r         <= 1'b0;
            ram_w         <= 1'b0;
            ram_add       <= '0;
            ram_d_in      <= '0;
        end else begin
            done <= 1'b0;
            if (mismatch) begin
                if (err_count != CNT_W'(DEPTH)) err_count <= err_count + 1'b1;
                if (err_count == '0) first_err_add <= pop.add;
            end
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        base_r        <= base;
                        stride_r      <= stride;
                        cnt_r         <= count;
                        err_count     <= '0;
                        first_err_add <= '0;
                        pass          <= 1'b0;
                        busy          <= 1'b1;
                        if (count == '0) begin
                            state <= S_DONE;
                        end else begin
                            state    <= S_WR;
                            ram_en   <= 1'b1;
                            ram_r    <= 1'b1;
                            ram_w    <= 1'b1;
                            ram_add  <= base;
                            ram_d_in <= pattern(base, SEED);
                            idx      <= CNT_W'(1);
                        end
                    end
                end
                S_WR: begin
                    if (idx == cnt_r) begin
                        state   <= S_RD;
                        ram_w   <= 1'b0;
                        ram_add <= base_r;
                        idx     <= CNT_W'(1);
                    end else begin
                        ram_add  <= next_add;
                        ram_d_in <= pattern(next_add, SEED);
                        idx      <= idx + 1'b1;
                    end
                end
                S_RD: begin
                    if (idx == cnt_r) begin
                        state  <= S_DRAIN;
                        ram_en <= 1'b0;
                        ram_r  <= 1'b0;
                        dcnt   <= '0;
                    end else begin
                        ram_add <= next_add;
                        idx     <= idx + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (dcnt == 2'(RD_LAT - 1)) state <= S_DONE;
                    else dcnt <= dcnt + 1'b1;
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (err_count == '0);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram16k_tester.sv
// Bench for ram16k_tester: two instances (read latency 1 and 3)
// against behavioural RAMs, checked cycle by cycle against a trace model.
module tb_ram16k_tester;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [13:0] base = '0;
    logic [13:0] stride = '0;
    logic [14:0] count = '0;
    int          sel = 1;
    bit          fault = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    logic        start1, start3;
    assign start1 = start && (sel == 1);
    assign start3 = start && (sel == 3);

    logic        busy1, done1, pass1, en1, r1, w1;
    logic [14:0] err1;
    logic [13:0] fea1, add1;
    logic [15:0] din1, dout1;
    logic        busy3, done3, pass3, en3, r3, w3;
    logic [14:0] err3;
    logic [13:0] fea3, add3;
    logic [15:0] din3, dout3;

    ram16k_tester #(.RD_LAT(1), .SEED(16'h0000)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .base(base),
        .stride(stride), .count(count), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .first_err_add(fea1),
        .ram_en(en1), .ram_r(r1), .ram_w(w1), .ram_add(add1),
        .ram_d_in(din1), .ram_d_out(dout1)
    );

    ram16k_tester #(.RD_LAT(3), .SEED(16'hA5A5)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .base(base),
        .stride(stride), .count(count), .busy(busy3), .done(done3),
        .pass(pass3), .err_count(err3), .first_err_add(fea3),
        .ram_en(en3), .ram_r(r3), .ram_w(w3), .ram_add(add3),
        .ram_d_in(din3), .ram_d_out(dout3)
    );

    // Behavioural RAMs: data appears RD_LAT edges after the sampling edge
    logic [15:0] mem1 [16384];
    logic [15:0] mem3 [16384];
    logic [15:0] q1;
    logic [15:0] s0, s1, s2;

    always @(posedge clk) begin
        if (en1 && w1) mem1[add1] <= din1;
        if (en1 && !w1) q1 <= mem1[add1];
        if (en3 && w3) mem3[add3] <= din3;
        s0 <= (en3 && !w3) ? mem3[add3] : 16'h0;
        s1 <= s0;
        s2 <= s1;
    end

    assign dout1 = q1 | {15'h0, fault};
    assign dout3 = s2 | {15'h0, fault};

    logic        o_busy, o_done, o_pass, o_en, o_r, o_w;
    logic [14:0] o_err;
    logic [13:0] o_fea, o_add;
    logic [15:0] o_din;

    always_comb begin
        o_busy = busy1; o_done = done1; o_pass = pass1;
        o_en = en1; o_r = r1; o_w = w1;
        o_err = err1; o_fea = fea1; o_add = add1; o_din = din1;
        if (sel == 3) begin
            o_busy = busy3; o_done = done3; o_pass = pass3;
            o_en = en3; o_r = r3; o_w = w3;
            o_err = err3; o_fea = fea3; o_add = add3; o_din = din3;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int addr_k(input int b, input int s, input int k);
        return (b + k * s) % 16384;
    endfunction

    function automatic int pat(input int a, input int seed);
        return (a ^ seed) & 16'hFFFF;
    endfunction

    // One run: every cycle after the start edge is compared with the trace
    // the rules imply; returns the cycle index at which done was seen.
    task automatic run(input int l, input int b, input int s, input int c,
                       input bit restart, output int done_at);
        int dj, ens, m_err, m_first, seed, last_add, last_din, a, p;
        seed = (l == 3) ? 16'hA5A5 : 0;
        dj = (c == 0) ? 1 : 2 * c + l + 1;
        m_err = 0;
        m_first = 0;
        for (int k = 0; k < c; k++) begin
            a = addr_k(b, s, k);
            p = pat(a, seed);
            if (fault && (p % 2 == 0)) begin
                if (m_err == 0) m_first = a;
                m_err++;
            end
        end
        if (m_err > 16384) m_err = 16384;
        sel = l;
        @(negedge clk);
        last_add = o_add;
        last_din = o_din;
        base = 14'(b); stride = 14'(s); count = 15'(c);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ens = 0;
        done_at = -1;
        for (int j = 0; j <= dj + 1; j++) begin
            bit xe, xw;
            int xa;
            @(negedge clk);
            xe = (j < 2 * c);
            xw = (j < c);
            xa = xw ? addr_k(b, s, j) : addr_k(b, s, j - c);
            chk("ram_en", 32'(o_en), 32'(xe));
            chk("ram_r", 32'(o_r), 32'(xe));
            chk("ram_w", 32'(o_w), 32'(xe && xw));
            if (xe) begin
                chk("ram_add", 32'(o_add), 32'(xa));
                last_add = xa;
                if (xw) begin
                    chk("ram_d_in", 32'(o_din), 32'(pat(xa, seed)));
                    last_din = pat(xa, seed);
                end
            end else begin
                chk("add_hold", 32'(o_add), 32'(last_add));
                chk("din_hold", 32'(o_din), 32'(last_din));
            end
            if (o_en) ens++;
            if (o_done && done_at < 0) done_at = j;
            chk("done", 32'(o_done), 32'(j == dj));
            chk("busy", 32'(o_busy), 32'(j < dj));
            if (j == dj) begin
                chk("pass", 32'(o_pass), 32'(m_err == 0));
                chk("err_count", 32'(o_err), 32'(m_err));
                chk("first_err_add", 32'(o_fea), 32'(m_first));
            end
            if (restart && j == 2) start = 1'b1;
            if (restart && j == 3) start = 1'b0;
        end
        chk("ram_cycles", 32'(ens), 32'(2 * c));
    endtask

    initial begin
        int d;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_done", 32'(done1), 0);
        chk("rst_pass", 32'(pass1), 0);
        chk("rst_err", 32'(err1), 0);
        chk("rst_fea", 32'(fea1), 0);
        chk("rst_en", 32'({en1, r1, w1}), 0);
        chk("rst_add", 32'(add1), 0);
        chk("rst_din", 32'(din1), 0);
        @(negedge clk);
        rst = 1'b0;

        // Model pins
        chk("model_a1", 32'(addr_k(2, 2048, 1)), 32'd2050);
        chk("model_a7", 32'(addr_k(2, 2048, 7)), 32'd14338);
        chk("model_b1", 32'(addr_k(16000, 1000, 1)), 32'd616);
        chk("model_b2", 32'(addr_k(16000, 1000, 2)), 32'd1616);

        run(1, 2, 2048, 8, 1'b0, d);
        chk("t1_done_cycle", 32'(d), 32'd18);
        chk("t1_pass", 32'(o_pass), 1);
        chk("t1_err", 32'(o_err), 0);

        run(1, 16000, 1000, 3, 1'b0, d);
        chk("t2_pass", 32'(o_pass), 1);

        fault = 1'b1;
        run(1, 2, 2048, 8, 1'b0, d);
        chk("t3_err", 32'(o_err), 32'd8);
        chk("t3_fea", 32'(o_fea), 32'd2);
        chk("t3_pass", 32'(o_pass), 0);
        fault = 1'b0;

        run(3, 100, 77, 4, 1'b0, d);
        chk("t4_done_cycle", 32'(d), 32'd12);
        chk("t4_pass", 32'(o_pass), 1);

        fault = 1'b1;
        run(3, 5, 0, 5, 1'b0, d);
        fault = 1'b0;

        run(1, 9, 9, 0, 1'b0, d);
        chk("t5_done_cycle", 32'(d), 32'd1);
        chk("t5_pass", 32'(o_pass), 1);

        run(1, 300, 0, 8, 1'b1, d);
        chk("t6_pass", 32'(o_pass), 1);

        // Reset during the third write cycle
        sel = 1;
        @(negedge clk);
        base = 14'd40; stride = 14'd3; count = 15'd8;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t7_wr_active", 32'({en1, w1}), 32'b11);
        rst = 1'b1;
        #1;
        chk("t7_en", 32'({en1, r1, w1}), 0);
        chk("t7_busy", 32'({busy1, done1, pass1}), 0);
        chk("t7_err", 32'(err1), 0);
        chk("t7_fea", 32'(fea1), 0);
        chk("t7_add", 32'(add1), 0);
        chk("t7_din", 32'(din1), 0);
        @(negedge clk);
        rst = 1'b0;
        run(1, 40, 3, 8, 1'b0, d);
        chk("t7_rerun_pass", 32'(o_pass), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
